// File: rtl/uart_rx.sv
// 8N1-style UART receiver: synchronizes the serial line, frames start/data/stop
// bits with a bit-period counter and reports good bytes, framing and overrun events.
module uart_rx #(
   parameter int CLKS_PER_BIT = 16,
   parameter int DATA_BITS    = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 rx,
   input  logic                 fifo_full,
   output logic [DATA_BITS-1:0] rx_data,
   output logic                 rx_valid,
   output logic                 frame_err,
   output logic                 overrun_err,
   output logic                 busy
);

   localparam int CNT_W = $clog2(CLKS_PER_BIT);
   localparam int IDX_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
   localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CNT_W-1:0] BIT_END = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [IDX_W-1:0] IDX_END = IDX_W'(DATA_BITS - 1);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_START = 3'd1,
      S_DATA  = 3'd2,
      S_STOP  = 3'd3,
      S_BREAK = 3'd4
   } state_t;

   state_t               state_q, state_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic [IDX_W-1:0]     idx_q, idx_d;
   logic [DATA_BITS-1:0] shift_q, shift_d;
   logic [DATA_BITS-1:0] data_q, data_d;
   logic                 valid_q, valid_d;
   logic                 ferr_q, ferr_d;
   logic                 oerr_q, oerr_d;
   logic                 busy_q, busy_d;
   logic                 sync1_q, sync2_q;
   logic                 rx_s;

   assign rx_s = sync2_q;

   // Two-flop synchronizer for the asynchronous serial line, idling high
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1_q <= 1'b1;
         sync2_q <= 1'b1;
      end else begin
         sync1_q <= rx;
         sync2_q <= sync1_q;
      end
   end

   // Next-state logic for the receive FSM and its registered outputs
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      shift_d = shift_q;
      data_d  = data_q;
      valid_d = 1'b0;
      ferr_d  = 1'b0;
      oerr_d  = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (!rx_s) begin
               state_d = S_START;
               cnt_d   = {CNT_W{1'b0}};
            end else begin
               state_d = S_IDLE;
            end
         end
         S_START: begin
            // Mid start bit: a high line here means the low was only a glitch
            if (cnt_q == HALF_M1) begin
               cnt_d = {CNT_W{1'b0}};
               if (!rx_s) begin
                  state_d = S_DATA;
                  idx_d   = {IDX_W{1'b0}};
               end else begin
                  state_d = S_IDLE;
               end
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         S_DATA: begin
            if (cnt_q == BIT_END) begin
               cnt_d   = {CNT_W{1'b0}};
               shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
               if (idx_q == IDX_END) begin
                  state_d = S_STOP;
                  idx_d   = {IDX_W{1'b0}};
               end else begin
                  idx_d = idx_q + IDX_W'(1);
               end
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         S_STOP: begin
            if (cnt_q == BIT_END) begin
               cnt_d = {CNT_W{1'b0}};
               if (rx_s) begin
                  state_d = S_IDLE;
                  if (fifo_full) begin
                     oerr_d = 1'b1;
                  end else begin
                     data_d  = shift_q;
                     valid_d = 1'b1;
                  end
               end else begin
                  state_d = S_BREAK;
                  ferr_d  = 1'b1;
               end
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         S_BREAK: begin
            if (rx_s) begin
               state_d = S_IDLE;
            end else begin
               state_d = S_BREAK;
            end
         end
         default: begin
            state_d = S_IDLE;
            cnt_d   = {CNT_W{1'b0}};
            idx_d   = {IDX_W{1'b0}};
         end
      endcase
      busy_d = (state_d != S_IDLE);
   end

   // State and output registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         cnt_q   <= {CNT_W{1'b0}};
         idx_q   <= {IDX_W{1'b0}};
         shift_q <= {DATA_BITS{1'b0}};
         data_q  <= {DATA_BITS{1'b0}};
         valid_q <= 1'b0;
         ferr_q  <= 1'b0;
         oerr_q  <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         shift_q <= shift_d;
         data_q  <= data_d;
         valid_q <= valid_d;
         ferr_q  <= ferr_d;
         oerr_q  <= oerr_d;
         busy_q  <= busy_d;
      end
   end

   assign rx_data     = data_q;
   assign rx_valid    = valid_q;
   assign frame_err   = ferr_q;
   assign overrun_err = oerr_q;
   assign busy        = busy_q;

endmodule
